// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes and FSM states.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} dmem_state_t;

endpackage

// File: rtl/dmem_lane_ctrl.sv
// Byte-lane steering for one 32-bit word: store enables/shift, load extract/extend.
// Misaligned accesses are aligned down; the misalign flag lets the top decide whether that is an error.
module dmem_lane_ctrl
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  input  logic        ld_unsigned,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] ldata,
  output logic        misalign
);

  logic [1:0]  sz;
  logic [1:0]  a;
  logic [31:0] sh;

  always_comb begin
    sz       = (size == SZ_RSVD) ? SZ_WORD : size;
    misalign = (size == SZ_RSVD) || (size == SZ_HALF && lane[0]) ||
               (size == SZ_WORD && lane != 2'b00);
    a        = lane;
    be       = 4'b0000;
    case (sz)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: begin a = {lane[1], 1'b0}; be = 4'b0011 << a; end
      default: begin a = 2'b00; be = 4'b1111; end
    endcase
    wword = wdata << {a, 3'b000};
    sh    = rword >> {a, 3'b000};
    case (sz)
      SZ_BYTE: ldata = {{24{~ld_unsigned & sh[7]}}, sh[7:0]};
      SZ_HALF: ldata = {{16{~ld_unsigned & sh[15]}}, sh[15:0]};
      default: ldata = sh;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// RV32I data-port responder: request capture, wait states, byte/half/word RAM access.
// Define DMEM_ERR_EN to flag misaligned, reserved-size and out-of-range requests via err.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  d_size,
  input  logic        ld_unsigned,
  output logic        ready,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int         DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_t           state;
  logic [3:0]            cnt;
  logic                  we_q, uns_q;
  logic [31:0]           addr_q, wdata_q, rd_word, wword, ldata;
  logic [1:0]            size_q;
  logic [3:0]            be;
  logic                  misalign, oor, err_c;
  logic [ADDR_WIDTH-1:0] widx;
  logic [31:0]           mem [DEPTH];

  assign widx = addr_q[ADDR_WIDTH+1:2];
  assign oor  = (addr_q >> (ADDR_WIDTH + 2)) != 32'd0;

`ifdef DMEM_ERR_EN
  assign err_c = misalign | oor;
`else
  // Without error checking, misaligned accesses align down and high bits wrap.
  logic unused_flags;
  assign unused_flags = misalign ^ oor;
  assign err_c        = 1'b0;
`endif

  dmem_lane_ctrl u_lane (
    .size        (size_q),
    .lane        (addr_q[1:0]),
    .wdata       (wdata_q),
    .rword       (rd_word),
    .ld_unsigned (uns_q),
    .be          (be),
    .wword       (wword),
    .ldata       (ldata),
    .misalign    (misalign)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      ready   <= 1'b0;
      rdata   <= '0;
      err     <= 1'b0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: if (req) begin
          we_q    <= we;
          addr_q  <= addr;
          wdata_q <= wdata;
          size_q  <= d_size;
          uns_q   <= ld_unsigned;
          cnt     <= CNT_INIT;
          state   <= (WAIT_STATES > 0) ? WAIT : ACCESS;
        end
        WAIT: begin
          if (cnt == 4'd0) state <= ACCESS;
          else             cnt   <= cnt - 4'd1;
        end
        ACCESS: state <= RESP;
        RESP: begin
          // rd_word was captured at the ACCESS edge; extension is combinational on it.
          ready <= 1'b1;
          rdata <= (we_q || err_c) ? 32'd0 : ldata;
          err   <= err_c;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM is not reset; a store only lands on the ACCESS edge.
  always_ff @(posedge clk) begin
    if (state == ACCESS) begin
      rd_word <= mem[widx];
      if (we_q && !err_c)
        for (int b = 0; b < 4; b++)
          if (be[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: WAIT_STATES=1 instance for the main sequence, WAIT_STATES=0 for back-to-back.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we, ld_unsigned, ready, err;
  logic [31:0] addr, wdata, rdata;
  logic [1:0]  d_size;
  logic        req0, we0, uns0, ready0, err0;
  logic [31:0] addr0, wdata0, rdata0;
  logic [1:0]  size0;
  int          checks = 0;
  int          errors = 0;
  logic [13:0] pat;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(1)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .d_size(d_size), .ld_unsigned(ld_unsigned), .ready(ready), .rdata(rdata), .err(err)
  );

  dmem_responder #(.ADDR_WIDTH(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
    .d_size(size0), .ld_unsigned(uns0), .ready(ready0), .rdata(rdata0), .err(err0)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  // One request on the WAIT_STATES=1 instance; inputs are scrambled after accept.
  task automatic xact(input string tag, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input logic u, input logic [31:0] exp_rd,
                      input logic exp_err);
    int lat;
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; d_size = sz; ld_unsigned = u;
    @(posedge clk); #1;
    req = 1'b0; we = ~w; addr = 32'hFFFF_FFFF; wdata = ~d; d_size = ~sz; ld_unsigned = ~u;
    lat = 0;
    while (ready !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({tag, " lat"}, 32'(lat), 32'd3);
    chk({tag, " rdata"}, rdata, exp_rd);
    chk({tag, " err"}, {31'd0, err}, {31'd0, exp_err});
    @(posedge clk); #1;
    chk({tag, " pulse"}, {31'd0, ready}, 32'd0);
  endtask

  task automatic xact0(input string tag, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] exp_rd);
    int lat;
    @(negedge clk);
    req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; size0 = SZ_WORD; uns0 = 1'b0;
    @(posedge clk); #1;
    req0 = 1'b0;
    lat = 0;
    while (ready0 !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    chk({tag, " lat"}, 32'(lat), 32'd2);
    chk({tag, " rdata"}, rdata0, exp_rd);
  endtask

  initial begin
    reset = 1'b1;
    req = 0; we = 0; addr = 0; wdata = 0; d_size = 0; ld_unsigned = 0;
    req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0; size0 = 0; uns0 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst ready", {31'd0, ready}, 32'd0);
    chk("rst rdata", rdata, 32'd0);
    chk("rst err", {31'd0, err}, 32'd0);
    @(negedge clk); reset = 1'b0;

    xact("st w 10", 1, 32'h10, 32'hDEADBEEF, SZ_WORD, 0, 32'h0, 0);
    xact("ld w 10", 0, 32'h10, 32'h0, SZ_WORD, 0, 32'hDEADBEEF, 0);
    xact("st b 11", 1, 32'h11, 32'h12345680, SZ_BYTE, 0, 32'h0, 0);
    xact("ld bs 11", 0, 32'h11, 32'h0, SZ_BYTE, 0, 32'hFFFFFF80, 0);
    xact("ld bu 11", 0, 32'h11, 32'h0, SZ_BYTE, 1, 32'h00000080, 0);
    xact("ld w 10b", 0, 32'h10, 32'h0, SZ_WORD, 0, 32'hDEAD80EF, 0);

    xact("st w 20", 1, 32'h20, 32'hCAFEF00D, SZ_WORD, 0, 32'h0, 0);
    xact("st h 22", 1, 32'h22, 32'hFFFF1234, SZ_HALF, 0, 32'h0, 0);
    xact("ld hs 22", 0, 32'h22, 32'h0, SZ_HALF, 0, 32'h00001234, 0);
    xact("ld w 20", 0, 32'h20, 32'h0, SZ_WORD, 0, 32'h1234F00D, 0);
    xact("ld hs 20", 0, 32'h20, 32'h0, SZ_HALF, 0, 32'hFFFFF00D, 0);
    xact("ld hu 20", 0, 32'h20, 32'h0, SZ_HALF, 1, 32'h0000F00D, 0);
    xact("ld b 23", 0, 32'h23, 32'h0, SZ_BYTE, 0, 32'h00000012, 0);

    xact("st w 0", 1, 32'h0, 32'h55AA55AA, SZ_WORD, 0, 32'h0, 0);
`ifdef DMEM_ERR_EN
    xact("err ld w 13", 0, 32'h13, 32'h0, SZ_WORD, 0, 32'h0, 1);
    xact("err ld h 21", 0, 32'h21, 32'h0, SZ_HALF, 0, 32'h0, 1);
    xact("err st oor", 1, 32'h400, 32'h11111111, SZ_WORD, 0, 32'h0, 1);
    xact("err st rsvd", 1, 32'h10, 32'h22222222, SZ_RSVD, 0, 32'h0, 1);
    xact("rb w 0", 0, 32'h0, 32'h0, SZ_WORD, 0, 32'h55AA55AA, 0);
    xact("rb w 10", 0, 32'h10, 32'h0, SZ_WORD, 0, 32'hDEAD80EF, 0);
`else
    xact("al ld w 13", 0, 32'h13, 32'h0, SZ_WORD, 0, 32'hDEAD80EF, 0);
    xact("al ld h 23", 0, 32'h23, 32'h0, SZ_HALF, 0, 32'h00001234, 0);
    xact("rsvd ld 22", 0, 32'h22, 32'h0, SZ_RSVD, 0, 32'h1234F00D, 0);
    xact("wrap st 400", 1, 32'h400, 32'h11111111, SZ_WORD, 0, 32'h0, 0);
    xact("wrap rb 0", 0, 32'h0, 32'h0, SZ_WORD, 0, 32'h11111111, 0);
`endif

    // Reset while a store is in WAIT: the store must not land.
    xact("st w 30", 1, 32'h30, 32'hA5A5A5A5, SZ_WORD, 0, 32'h0, 0);
    xact("ld w 30", 0, 32'h30, 32'h0, SZ_WORD, 0, 32'hA5A5A5A5, 0);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h30; wdata = 32'h0BADF00D; d_size = SZ_WORD;
    @(posedge clk); #1;
    req = 1'b0;
    chk("pre-rst in WAIT", 32'(dut.state), 32'(WAIT));
    reset = 1'b1; #1;
    chk("mid-rst ready", {31'd0, ready}, 32'd0);
    chk("mid-rst rdata", rdata, 32'd0);
    chk("mid-rst err", {31'd0, err}, 32'd0);
    chk("mid-rst state", 32'(dut.state), 32'(IDLE));
    repeat (2) @(posedge clk);
    #1;
    chk("rst hold ready", {31'd0, ready}, 32'd0);
    @(negedge clk); reset = 1'b0;
    xact("ld w 30 old", 0, 32'h30, 32'h0, SZ_WORD, 0, 32'hA5A5A5A5, 0);

    // Zero wait states, req held high with fresh data every cycle.
    xact0("ws0 st w1", 1, 32'h4, 32'hFFFFFFFF, 32'h0);
    xact0("ws0 st w2", 1, 32'h8, 32'h22222222, 32'h0);
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0; wdata0 = 32'd100; size0 = SZ_WORD;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      pat[c] = ready0;
      @(negedge clk);
      if (c < 11) begin addr0 = 32'(4 * (c + 1)); wdata0 = 32'(100 + c + 1); end
      else req0 = 1'b0;
    end
    chk("ws0 ready pattern", {18'd0, pat}, 32'h0924);
    xact0("ws0 rb w0", 0, 32'h0, 32'h0, 32'd100);
    xact0("ws0 rb w1", 0, 32'h4, 32'h0, 32'hFFFFFFFF);
    xact0("ws0 rb w2", 0, 32'h8, 32'h0, 32'h22222222);
    xact0("ws0 rb w3", 0, 32'hC, 32'h0, 32'd103);
    xact0("ws0 rb w6", 0, 32'h18, 32'h0, 32'd106);
    xact0("ws0 rb w9", 0, 32'h24, 32'h0, 32'd109);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
